dac_channel_scheduler: RTL
==========================

// Module: dac_channel_scheduler
// PURPOSE
//  Shares one SPI DAC transmitter (32-bit frame spi core) between NREQ channel requesters.
//  Issues the power-up DAC clear, round-robin arbitrates pending requests and builds the write frames.
//  Sequences one frame at a time, then acknowledges the requester that was served.
//  Sits between the waveform/generator channels and the spi instance that drives the DAC pins.
// PARAMETERS
//  NREQ          4                      number of requesters (2..8)
//  COMMAND       4'b0011                DAC command nibble (write and update)
//  CH_ADDR       16'h3210               DAC channel address per requester, nibble i -> requester i
//  CLR_CYCLES    4                      cycles dac_clr is held low after reset release (>=1)
//  START_TIMEOUT 16                     max cycles from spi_en until spi_ss falls
// PORTS
//  clk        in   1         system clock, all logic on posedge
//  rst        in   1         synchronous reset, ACTIVE-LOW (rst==0 resets on the next clk edge)
//  req        in   NREQ      req[i]=1: requester i has a sample pending
//  data       in   12*NREQ   sample of requester i at data[12*i+:12]
//  ack        out  NREQ      one-cycle pulse: frame of requester i is complete
//  spi_en     out  1         one-cycle start pulse to spi core
//  spi_data   out  32        frame to spi core {8'd0, COMMAND, CH_ADDR[i], sample, 4'd0}
//  spi_ss     in   1         spi core chip select, low while a frame shifts
//  dac_clr    out  1         DAC clear, active-low
//  busy       out  1         1 from grant until ack or timeout
//  timeout_err out 1         one-cycle pulse: spi_ss did not fall within START_TIMEOUT
// BEHAVIOUR
//  Reset (rst==0 at edge): state CLEAR, cnt=0, rr_ptr=0. All outputs 0, including dac_clr (DAC cleared).
//  FSM states: CLEAR, ARB, LOAD, WAIT_START, WAIT_DONE, ACK.
//   CLEAR: dac_clr=0 for CLR_CYCLES cycles after rst goes high, then ARB. dac_clr=1 in every other state.
//   ARB: if no req, stay in ARB.
//        Otherwise grant the first set req[i] searching i = rr_ptr, rr_ptr+1, ... modulo NREQ.
//        Latch g=i and spi_data (sample captured this edge), busy<=1, go to LOAD.
//   LOAD: spi_en=1 for exactly this one cycle, clear timer, go to WAIT_START.
//   WAIT_START: spi_ss==0 -> WAIT_DONE.
//        Timer reaching START_TIMEOUT -> timeout_err pulse, busy<=0, rr_ptr<=g+1, ARB, no ack.
//   WAIT_DONE: spi_ss==1 -> ACK. No timeout in this state.
//   ACK: ack[g]=1 for one cycle, busy<=0, rr_ptr<=(g+1) mod NREQ, go to ARB.
//  Throughput: at most one grant per frame; ARB->LOAD->WAIT_START adds 2 cycles plus spi latency.
//  Handshake: requester holds req and data until its ack.
//   Data is sampled only at the grant edge, so later data changes do not affect the frame in flight.
//   req may drop before grant (request withdrawn).
//   req dropping after grant is ignored; the frame completes and ack still pulses.
//   A requester that re-asserts req in the ack cycle is not served before all other pending requesters (round robin).
//  Simultaneous events: at most one ack bit high per cycle. ack and timeout_err are never high together.
//   spi_ss falling in the LOAD cycle itself is treated as started (WAIT_START exits on the next cycle).
//  Reset mid-frame: everything returns to CLEAR and spi_en goes 0. No ack is issued for the aborted frame.
//  Width rules: rr_ptr and g are $clog2(NREQ) bits and wrap NREQ-1 -> 0. Timer is $clog2(START_TIMEOUT+1) bits and saturates.
// STRUCTURE
//  Shared package/header (dac_pkg): FSM state localparams, FRAME_W=32, DAC command codes, frame field offsets.
//  Sub-module rr_arbiter: req, rr_ptr -> one-hot grant + index, purely combinational.
//  Top module holds the FSM, counters and frame register.
// TESTING (CH_ADDR=16'h3210, COMMAND=4'b0011, spi core model: ss low 2 cycles after en, for 34 cycles)
//  1. rst=0 for 3 cycles, then 1 -> outputs 0 during reset; dac_clr=0 for 4 more cycles, then 1; no spi_en while req=0.
//  2. req=4'b0100, data[35:24]=12'hABC -> one spi_en pulse with spi_data=32'h0032ABC0.
//     ack=4'b0100 one cycle after ss rises; busy high from grant to ack.
//  3. req=4'b1111 held, acks not deasserting -> grant order 0,1,2,3,0.
//     Then req=4'b1001 held -> order alternates 0,3,0,3.
//  4. Core model never lowers ss -> timeout_err pulses 16 cycles after spi_en, no ack, busy=0.
//     Next grant goes to the following requester.
//  5. req[1] dropped and data[1] changed mid-frame -> frame keeps the sample latched at grant; ack[1] still pulses.
//  6. rst=0 during WAIT_DONE -> next cycle all outputs 0 and state CLEAR; after release the CLEAR sequence repeats and no stale ack appears.

Source files
------------

// File: rtl/dac_channel_scheduler_pkg.sv
// Shared definitions for the DAC channel scheduler: FSM states, frame layout
// and the DAC command codes.
`timescale 1ns/1ps
package dac_channel_scheduler_pkg;

    localparam int FRAME_W  = 32;
    localparam int SAMPLE_W = 12;
    localparam int ADDR_W   = 4;
    localparam int CMD_W    = 4;

    // Frame field offsets: {8'd0, cmd[23:20], addr[19:16], sample[15:4], 4'd0}
    localparam int CMD_LSB  = 20;
    localparam int ADDR_LSB = 16;
    localparam int DATA_LSB = 4;

    localparam logic [CMD_W-1:0] CMD_WRITE        = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_UPDATE       = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_WRITE_UPD_ALL = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_WRITE_UPDATE = 4'b0011;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_ARB,
        ST_LOAD,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_ACK
    } state_e;

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [CMD_W-1:0]    cmd,
        input logic [ADDR_W-1:0]   addr,
        input logic [SAMPLE_W-1:0] sample
    );
        logic [FRAME_W-1:0] f;
        f = '0;
        f[CMD_LSB  +: CMD_W]    = cmd;
        f[ADDR_LSB +: ADDR_W]   = addr;
        f[DATA_LSB +: SAMPLE_W] = sample;
        return f;
    endfunction

endpackage

// File: rtl/dac_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i,
// returned both one-hot and as an index.
`timescale 1ns/1ps
module dac_channel_scheduler_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            vld_o
);

    logic [2*NREQ-1:0]      req_dbl;
    logic [2*NREQ-1:0]      gnt_dbl;
    logic [NREQ-1:0]        rot;
    logic [NREQ-1:0]        first;
    logic [NREQ:0]          seen;
    logic [NREQ:0][PW-1:0]  idx_acc;

    // Rotate so bit 0 is the pointer position, pick the lowest set bit, rotate back.
    assign req_dbl = {req_i, req_i} >> ptr_i;
    assign rot     = req_dbl[NREQ-1:0];
    assign seen[0] = 1'b0;

    for (genvar k = 0; k < NREQ; k++) begin : g_pick
        assign first[k]  = rot[k] & ~seen[k];
        assign seen[k+1] = seen[k] | rot[k];
    end

    assign gnt_dbl = {first, first} << ptr_i;
    assign gnt_o   = gnt_dbl[2*NREQ-1:NREQ];
    assign vld_o   = seen[NREQ];

    assign idx_acc[0] = '0;
    for (genvar j = 0; j < NREQ; j++) begin : g_enc
        assign idx_acc[j+1] = idx_acc[j] | ({PW{gnt_o[j]}} & PW'(j));
    end
    assign idx_o = idx_acc[NREQ];

endmodule

// File: rtl/dac_channel_scheduler.sv
// Shares one SPI DAC transmitter between NREQ requesters: power-up clear,
// round-robin grant, frame build, start/done sequencing and per-requester ack.
`timescale 1ns/1ps
module dac_channel_scheduler
    import dac_channel_scheduler_pkg::*;
#(
    parameter int                NREQ          = 4,
    parameter logic [CMD_W-1:0]  COMMAND       = CMD_WRITE_UPDATE,
    parameter logic [4*NREQ-1:0] CH_ADDR       = 16'h3210,
    parameter int                CLR_CYCLES    = 4,
    parameter int                START_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [12*NREQ-1:0]     data,
    output logic [NREQ-1:0]        ack,
    output logic                   spi_en,
    output logic [FRAME_W-1:0]     spi_data,
    input  logic                   spi_ss,
    output logic                   dac_clr,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int PW  = $clog2(NREQ);
    localparam int TW  = $clog2(START_TIMEOUT + 1);
    localparam int CW  = $clog2(CLR_CYCLES + 1);
    localparam int SEL = ADDR_W + SAMPLE_W;

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [TW-1:0]        timer_q;
    logic [PW-1:0]        rr_ptr_q;
    logic [PW-1:0]        g_q;
    logic [NREQ-1:0]      g_oh_q;
    logic                 ss_seen_q;
    logic [FRAME_W-1:0]   spi_data_q;
    logic                 spi_en_q;
    logic [NREQ-1:0]      ack_q;
    logic                 busy_q;
    logic                 dac_clr_q;
    logic                 timeout_q;

    logic [NREQ-1:0]      gnt;
    logic [PW-1:0]        gnt_idx;
    logic                 gnt_vld;
    logic [NREQ:0][SEL-1:0] sel_acc;
    logic [ADDR_W-1:0]    sel_addr;
    logic [SAMPLE_W-1:0]  sel_sample;
    logic [PW-1:0]        next_ptr;

    dac_channel_scheduler_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    // One-hot AND-OR select of the granted requester's address nibble and sample.
    assign sel_acc[0] = '0;
    for (genvar i = 0; i < NREQ; i++) begin : g_sel
        assign sel_acc[i+1] = sel_acc[i] |
            ({SEL{gnt[i]}} & {CH_ADDR[4*i +: 4], data[12*i +: 12]});
    end
    assign {sel_addr, sel_sample} = sel_acc[NREQ];

    assign next_ptr = (g_q == PW'(NREQ - 1)) ? '0 : g_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            timer_q    <= '0;
            rr_ptr_q   <= '0;
            g_q        <= '0;
            g_oh_q     <= '0;
            ss_seen_q  <= 1'b0;
            spi_data_q <= '0;
            spi_en_q   <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            dac_clr_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            spi_en_q  <= 1'b0;
            ack_q     <= '0;
            timeout_q <= 1'b0;
            unique case (state_q)
                ST_CLEAR: begin
                    if (cnt_q == CW'(CLR_CYCLES - 1)) begin
                        dac_clr_q <= 1'b1;
                        state_q   <= ST_ARB;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ARB: begin
                    if (gnt_vld) begin
                        g_q        <= gnt_idx;
                        g_oh_q     <= gnt;
                        spi_data_q <= build_frame(COMMAND, sel_addr, sel_sample);
                        busy_q     <= 1'b1;
                        spi_en_q   <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Timer holds cycles elapsed since spi_en; a select already low here counts as started.
                    timer_q   <= TW'(1);
                    ss_seen_q <= ~spi_ss;
                    state_q   <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (!spi_ss || ss_seen_q) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (timer_q >= TW'(START_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        rr_ptr_q  <= next_ptr;
                        state_q   <= ST_ARB;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (spi_ss) begin
                        ack_q   <= g_oh_q;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    busy_q   <= 1'b0;
                    rr_ptr_q <= next_ptr;
                    state_q  <= ST_ARB;
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    assign ack         = ack_q;
    assign spi_en      = spi_en_q;
    assign spi_data    = spi_data_q;
    assign dac_clr     = dac_clr_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_q;

endmodule
